// File: rtl/mean_sched_pkg.sv
// Shared types and constants for the mean_unit block scheduler.
// Holds the FSM state encoding, the default result record and the watchdog limit.
package mean_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        STREAM,
        WAIT
    } state_t;

    localparam int RES_MEAN_W = 8;
    localparam int RES_IDX_W  = 12;

    typedef struct packed {
        logic [RES_MEAN_W-1:0] mean;
        logic [RES_IDX_W-1:0]  idx;
        logic                  last;
    } res_t;

    localparam int TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/mean_res_fifo.sv
// Synchronous result FIFO; DEPTH must be a power of two (>= 2).
// Push while full is accepted when a pop happens in the same cycle.
module mean_res_fifo
    import mean_sched_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = res_t,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  T              din_i,
    input  logic          pop_i,
    output T              dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | pop_i);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mean_block_sched.sv
// Cuts a frame into blocks, drives a mean_unit and queues per-block means.
// Define MEAN_SCHED_TIMEOUT_EN to add a watchdog on the WAIT state.
module mean_block_sched
    import mean_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int IDX_WIDTH  = 12,
    parameter int RES_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_WIDTH-1:0]  cfg_block_len,
    input  logic [IDX_WIDTH-1:0]  cfg_num_blocks,
    input  logic                  s_sof,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  mu_start,
    output logic                  mu_en,
    output logic [DATA_WIDTH-1:0] mu_data,
    output logic [LEN_WIDTH-1:0]  mu_total,
    input  logic [DATA_WIDTH-1:0] mu_mean,
    input  logic                  mu_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_mean,
    output logic [IDX_WIDTH-1:0]  m_idx,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  err
);

    localparam int CW = $clog2(RES_DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] mean;
        logic [IDX_WIDTH-1:0]  idx;
        logic                  last;
    } blk_res_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]  nblk_q, nblk_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  skid_v_q, skid_v_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  sofp_q, sofp_d;
    logic                  err_q, err_d;
    logic                  start_q, start_d;
    logic                  en_q, en_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    blk_res_t              push_res, pop_res, out_res;
    logic                  push, pop, full, empty;
    logic [CW-1:0]         fifo_cnt;
    logic                  sready_c, tmo, cfg_ok, last_blk, slot_free;

    assign pop       = m_ready & ~empty;
    assign slot_free = ~full | pop;
    assign cfg_ok    = (cfg_block_len != '0) && (cfg_num_blocks != '0);
    assign last_blk  = (idx_q == nblk_q - 1'b1);

`ifdef MEAN_SCHED_TIMEOUT_EN
    logic [15:0] wd_q;
    always_ff @(posedge clk) begin
        if (rst) wd_q <= '0;
        else if (state_q == WAIT && state_d == WAIT) wd_q <= wd_q + 16'd1;
        else wd_q <= '0;
    end
    assign tmo = (state_q == WAIT) && (wd_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        nblk_d   = nblk_q;
        idx_d    = idx_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        sofp_d   = sofp_q;
        err_d    = err_q;
        start_d  = 1'b0;
        en_d     = 1'b0;
        data_d   = data_q;
        sready_c = 1'b0;
        push     = 1'b0;
        push_res = '{mean: mu_mean, idx: idx_q, last: last_blk};
        if (mu_ready && state_q != WAIT) err_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                sready_c = 1'b1;
                if (s_valid && s_sof) begin
                    if (cfg_ok) begin
                        len_d    = cfg_block_len;
                        nblk_d   = cfg_num_blocks;
                        idx_d    = '0;
                        skid_v_d = 1'b1;
                        skid_d   = s_data;
                        sofp_d   = 1'b0;
                        state_d  = ARM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ARM: begin
                if (slot_free) begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // The skid sample is issued first, so new input waits a cycle.
                sready_c = ~skid_v_q;
                if (s_valid && sready_c && s_sof && !sofp_q) begin
                    err_d    = 1'b1;
                    len_d    = cfg_block_len;
                    nblk_d   = cfg_num_blocks;
                    idx_d    = '0;
                    skid_v_d = cfg_ok;
                    skid_d   = s_data;
                    sofp_d   = 1'b0;
                    state_d  = cfg_ok ? ARM : IDLE;
                end else if (skid_v_q || s_valid) begin
                    en_d     = 1'b1;
                    data_d   = skid_v_q ? skid_q : s_data;
                    skid_v_d = 1'b0;
                    sofp_d   = 1'b0;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) state_d = WAIT;
                end
            end
            WAIT: begin
                // SOF here is not accepted yet; let STREAM take it as frame start.
                if (s_valid && s_sof) begin
                    err_d    = 1'b1;
                    len_d    = cfg_block_len;
                    nblk_d   = cfg_num_blocks;
                    idx_d    = '0;
                    skid_v_d = 1'b0;
                    sofp_d   = cfg_ok;
                    state_d  = cfg_ok ? ARM : IDLE;
                end else if (mu_ready || tmo) begin
                    push = 1'b1;
                    if (!mu_ready) begin
                        err_d         = 1'b1;
                        push_res.mean = '0;
                    end
                    if (last_blk) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ARM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            nblk_q   <= '0;
            idx_q    <= '0;
            skid_v_q <= 1'b0;
            skid_q   <= '0;
            sofp_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            en_q     <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            nblk_q   <= nblk_d;
            idx_q    <= idx_d;
            skid_v_q <= skid_v_d;
            skid_q   <= skid_d;
            sofp_q   <= sofp_d;
            err_q    <= err_d;
            start_q  <= start_d;
            en_q     <= en_d;
            data_q   <= data_d;
        end
    end

    mean_res_fifo #(
        .DEPTH (RES_DEPTH),
        .T     (blk_res_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_res),
        .pop_i   (pop),
        .dout_o  (pop_res),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_cnt)
    );

    assign out_res  = empty ? '0 : pop_res;
    assign s_ready  = sready_c & ~rst;
    assign mu_start = start_q;
    assign mu_en    = en_q;
    assign mu_data  = data_q;
    assign mu_total = len_q;
    assign m_valid  = ~empty;
    assign m_mean   = out_res.mean;
    assign m_idx    = out_res.idx;
    assign m_last   = out_res.last;
    assign busy     = (state_q != IDLE) || (fifo_cnt != '0);
    assign err      = err_q;

endmodule
